polyphase_mac_scheduler: RTL and testbench

Sequencer for the shared multiply-accumulate unit of the decimate-by-2 halfband FIR. Writes accepted input samples into an external circular sample RAM. After every second accepted sample it issues one burst of tap beats: sample-RAM read address, coefficient-ROM address and MAC strobes. It then waits out the MAC pipeline and presents the accumulated result on a valid/ready output. It sits between the upstream sample source and the FIR datapath (sample RAM, coefficient ROM, MAC).

---
 rtl/polyphase_mac_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_polyphase_mac_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_mac_scheduler.sv
// polyphase_mac_scheduler: sequencer for the shared MAC of a decimate-by-2
// halfband FIR. It writes accepted samples into a circular sample RAM. After
// every second accepted sample it issues one burst of tap beats (RAM read
// address, ROM address, MAC strobes), waits out the MAC pipeline and then
// presents the accumulated result on a valid/ready output.
// Ports:
//   clk, reset_n (synchronous, active-low)
//   in_valid/in_ready/in_data     upstream sample handshake
//   buf_we/buf_waddr/buf_wdata    sample RAM write port
//   buf_raddr, coef_addr          RAM / ROM read addresses (1-cycle latency)
//   mac_en/mac_clear/mac_last     MAC strobes, one cycle behind the addresses
//   mac_acc                       MAC accumulator value
//   out_valid/out_ready/out_data  result handshake
// Build option: HALFBAND_SKIP_EN issues only the even taps plus the centre tap.
module polyphase_mac_scheduler #(
   parameter int SAMPLE_WIDTH = 6,
   parameter int ACC_WIDTH    = 24,
   parameter int ADDR_W       = 6,
   parameter int TAPS         = 31,
   parameter int MAC_LAT      = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SAMPLE_WIDTH-1:0]  in_data,
   output logic                     buf_we,
   output logic [ADDR_W-1:0]        buf_waddr,
   output logic [SAMPLE_WIDTH-1:0]  buf_wdata,
   output logic [ADDR_W-1:0]        buf_raddr,
   output logic [$clog2(TAPS)-1:0]  coef_addr,
   output logic                     mac_en,
   output logic                     mac_clear,
   output logic                     mac_last,
   input  logic [ACC_WIDTH-1:0]     mac_acc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_WIDTH-1:0]     out_data
);

`ifdef HALFBAND_SKIP_EN
   localparam int NB = (TAPS + 1) / 2 + 1;
`else
   localparam int NB = TAPS;
`endif
   localparam int CW  = $clog2(TAPS);
   localparam int FW  = $clog2(TAPS + 1);
   localparam int BW  = $clog2(NB + MAC_LAT + 1);
   localparam int CTR = (TAPS - 1) / 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_OUTPUT
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      wp_q, wp_d;
   logic                   phase_q, phase_d;
   logic [FW-1:0]          fill_q, fill_d;
   logic [ADDR_W-1:0]      newest_q, newest_d;
   logic [BW-1:0]          beat_q, beat_d;
   logic                   out_valid_q, out_valid_d;
   logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
   logic                   mac_en_q, mac_en_d;
   logic                   mac_clear_q, mac_clear_d;
   logic                   mac_last_q, mac_last_d;
   logic [CW-1:0]          tap;
   logic [BW:0]            beat_x2;

   // Beat number to true tap index.
   always_comb begin
      beat_x2 = {beat_q, 1'b0};
`ifdef HALFBAND_SKIP_EN
      if (beat_q == BW'(NB - 1)) tap = CW'(CTR);
      else                       tap = CW'(beat_x2);
`else
      tap = CW'(beat_q);
`endif
   end

   always_comb begin
      state_d     = state_q;
      wp_d        = wp_q;
      phase_d     = phase_q;
      fill_d      = fill_q;
      newest_d    = newest_q;
      beat_d      = beat_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      mac_en_d    = 1'b0;
      mac_clear_d = 1'b0;
      mac_last_d  = 1'b0;
      in_ready    = 1'b0;
      buf_we      = 1'b0;
      buf_wdata   = '0;
      buf_raddr   = '0;
      coef_addr   = '0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = reset_n;
            if (in_valid && reset_n) begin
               buf_we    = 1'b1;
               buf_wdata = in_data;
               wp_d      = wp_q + 1'b1;
               phase_d   = ~phase_q;
               if (fill_q != FW'(TAPS)) fill_d = fill_q + 1'b1;
               if (phase_q) begin
                  newest_d = wp_q;
                  beat_d   = '0;
                  state_d  = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            buf_raddr = newest_q - ADDR_W'(tap);
            coef_addr = tap;
            // Taps older than the stored history are skipped but still
            // occupy their beat, so the burst length never changes.
            mac_en_d    = (beat_q == '0) || (32'(tap) < 32'(fill_q));
            mac_clear_d = (beat_q == '0);
            mac_last_d  = (beat_q == BW'(NB - 1));
            if (beat_q == BW'(NB - 1)) begin
               beat_d  = '0;
               state_d = S_DRAIN;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (beat_q == BW'(MAC_LAT)) begin
               out_data_d  = mac_acc;
               out_valid_d = 1'b1;
               beat_d      = '0;
               state_d     = S_OUTPUT;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         S_OUTPUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         wp_q        <= '0;
         phase_q     <= 1'b0;
         fill_q      <= '0;
         newest_q    <= '0;
         beat_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         mac_en_q    <= 1'b0;
         mac_clear_q <= 1'b0;
         mac_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         phase_q     <= phase_d;
         fill_q      <= fill_d;
         newest_q    <= newest_d;
         beat_q      <= beat_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         mac_en_q    <= mac_en_d;
         mac_clear_q <= mac_clear_d;
         mac_last_q  <= mac_last_d;
      end
   end

   assign buf_waddr = wp_q;
   assign mac_en    = mac_en_q;
   assign mac_clear = mac_clear_q;
   assign mac_last  = mac_last_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_polyphase_mac_scheduler.sv
// Bench for polyphase_mac_scheduler: sample RAM, halfband ROM and a
// two-stage MAC around the DUT, checked against a direct FIR sum.
module tb_polyphase_mac_scheduler;
   localparam int SW   = 6;
   localparam int AW   = 24;
   localparam int ADW  = 6;
   localparam int TAPS = 31;
   localparam int ML   = 2;
   localparam int CW   = $clog2(TAPS);
   localparam int CTR  = (TAPS - 1) / 2;
`ifdef HALFBAND_SKIP_EN
   localparam int NB = (TAPS + 1) / 2 + 1;
`else
   localparam int NB = TAPS;
`endif

   logic           clk = 1'b0;
   logic           reset_n;
   logic           in_valid;
   logic           in_ready;
   logic [SW-1:0]  in_data;
   logic           buf_we;
   logic [ADW-1:0] buf_waddr;
   logic [SW-1:0]  buf_wdata;
   logic [ADW-1:0] buf_raddr;
   logic [CW-1:0]  coef_addr;
   logic           mac_en;
   logic           mac_clear;
   logic           mac_last;
   logic [AW-1:0]  mac_acc;
   logic           out_valid;
   logic           out_ready;
   logic [AW-1:0]  out_data;

   polyphase_mac_scheduler dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
      .buf_raddr(buf_raddr), .coef_addr(coef_addr),
      .mac_en(mac_en), .mac_clear(mac_clear), .mac_last(mac_last),
      .mac_acc(mac_acc),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   // Halfband coefficients: odd taps zero except the centre.
   function automatic int h(int k);
      if ((k % 2 == 1) && (k != CTR)) return 0;
      return k + 1;
   endfunction

   // ---------------- datapath environment ----------------
   logic [SW-1:0]        ram [64];
   logic [SW-1:0]        ram_q;
   int                   rom_q;
   int                   p1;
   logic                 v1, c1;
   logic signed [AW-1:0] acc;

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = '0;
      ram_q = '0; rom_q = 0; p1 = 0; v1 = 0; c1 = 0; acc = '0;
   end

   always @(posedge clk) begin
      if (buf_we) ram[buf_waddr] <= buf_wdata;
      ram_q <= ram[buf_raddr];
      rom_q <= h(int'(coef_addr));
      v1    <= mac_en;
      c1    <= mac_clear;
      p1    <= int'($signed(ram_q)) * rom_q;
      if (v1) acc <= (c1 ? '0 : acc) + AW'(p1);
   end
   assign mac_acc = acc;

   // ---------------- checking ----------------
   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int             hist[$];
   int             nacc = 0;
   int             tot = 0;
   int             exp_wp = 0;
   int             newest = 0;
   logic [AW-1:0]  expq[$];
   int             exp_men = 0;
   int             men_cnt = 0;
   int             acc_cyc = 0;
   int             cyc = 0;
   int             bcnt = -1;
   logic           prev_ov = 0;
   logic           prev_hs = 0;
   logic [AW-1:0]  prev_od = '0;
   logic           rst_seen = 0;

   function automatic int fill_now();
      return (nacc < TAPS) ? nacc : TAPS;
   endfunction

   function automatic logic [AW-1:0] ref_y();
      int s = 0;
      int f = fill_now();
      for (int k = 0; k < f; k++) s += h(k) * hist[nacc - 1 - k];
      return AW'(s);
   endfunction

   function automatic int tapk(int j);
`ifdef HALFBAND_SKIP_EN
      return (j == NB - 1) ? CTR : 2 * j;
`else
      return j;
`endif
   endfunction

   function automatic int ref_men(int f);
      int n = 0;
      for (int j = 0; j < NB; j++)
         if (j == 0 || tapk(j) < f) n++;
      return n;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         hist.delete();
         expq.delete();
         nacc = 0; exp_wp = 0; bcnt = -1;
         prev_ov = 0; prev_hs = 0;
         rst_seen = 1;
      end else begin
         if (rst_seen) begin
            chk("rst_in_ready", 32'(in_ready), 1);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_mac_en", 32'(mac_en), 0);
            chk("rst_waddr", 32'(buf_waddr), 0);
            rst_seen = 0;
         end
         if (bcnt >= 0) begin
            chk("raddr", 32'(buf_raddr), 32'((newest - tapk(bcnt) + 64) % 64));
            chk("coef_addr", 32'(coef_addr), 32'(tapk(bcnt)));
            bcnt++;
            if (bcnt == NB) bcnt = -1;
         end
         if (mac_en) men_cnt++;
         if (out_valid && !prev_ov) begin
            chk("latency", 32'(cyc - acc_cyc), 32'(NB + ML + 2));
            chk("mac_en_count", 32'(men_cnt), 32'(exp_men));
         end
         if (out_valid) begin
            chk("busy_in_ready", 32'(in_ready), 0);
            chk("busy_buf_we", 32'(buf_we), 0);
            if (prev_ov && !prev_hs)
               chk("hold_data", 32'(out_data), 32'(prev_od));
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("spurious_out", 32'(out_valid), 0);
            else chk("out_data", 32'(out_data), 32'(expq.pop_front()));
         end
         if (buf_we) begin
            chk("waddr", 32'(buf_waddr), 32'(exp_wp));
            chk("wdata", 32'(buf_wdata), 32'(in_data));
            hist.push_back(int'($signed(buf_wdata)));
            nacc++; tot++;
            exp_wp = (exp_wp + 1) % 64;
            if (nacc % 2 == 0) begin
               newest  = int'(buf_waddr);
               expq.push_back(ref_y());
               exp_men = ref_men(fill_now());
               men_cnt = 0;
               acc_cyc = cyc;
               bcnt    = 0;
            end
         end
         prev_ov = out_valid;
         prev_od = out_data;
         prev_hs = out_valid && out_ready;
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [SW-1:0] gen(int m);
      if (m == 0) return (nacc == 0) ? SW'(1) : SW'(0);
      if (m == 1) return SW'(nacc);
      return SW'($urandom);
   endfunction

   task automatic drive(int n, int vpct, int rpct, int m);
      int target = tot + n;
      int budget = n * 60 + 200;
      while (tot < target && budget > 0) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(99) < vpct);
         in_data   = gen(m);
         out_ready = ($urandom_range(99) < rpct);
         budget--;
      end
      if (tot < target) chk("drive_timeout", 32'(tot), 32'(target));
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      in_valid = 0;
      reset_n  = 0;
      @(posedge clk); #1;
      reset_n = 1;
   endtask

   initial begin
      int b;
      reset_n = 0; in_valid = 0; in_data = '0; out_ready = 0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1;

      drive(40, 100, 100, 0);

      // reset in the middle of a burst
      b = 300;
      while (!(bcnt >= 3) && b > 0) begin
         @(posedge clk); #1;
         in_valid = 1; in_data = SW'($urandom); out_ready = 1;
         b--;
      end
      chk("issue_reached", 32'(bcnt >= 3), 1);
      do_reset();

      drive(10, 100, 100, 0);

      // backpressure in OUTPUT with input pending
      out_ready = 0;
      b = 300;
      while (!out_valid && b > 0) begin
         @(posedge clk); #1;
         in_valid = 1; in_data = SW'($urandom);
         b--;
      end
      chk("bp_out_valid", 32'(out_valid), 1);
      repeat (10) @(posedge clk);
      #1 out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0; in_valid = 0;
      @(negedge clk);
      chk("bp_single_hs", 32'(out_valid), 0);

      do_reset();
      drive(200, 100, 100, 1);
      drive(200, 80, 70, 1);
      drive(100, 60, 60, 2);

      out_ready = 1; in_valid = 0;
      b = 400;
      while (expq.size() != 0 && b > 0) begin
         @(posedge clk);
         b--;
      end
      chk("final_drain", 32'(expq.size()), 0);
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
